idct_coef_feeder: RTL and testbench
===================================

Name: idct_coef_feeder

Overview:
- Source side of the idct_top coefficient stream; drives idct4/start/in exactly as idct_top expects: one signed 16-bit coefficient per clock, 16 for a 4x4 block, 64 for an 8x8 block.
- Accepts sparse, zigzag-ordered coefficient writes from the entropy/dequant stage into a two-bank ping-pong buffer.
- Streams each completed block in raster order.
- Unwritten positions read as zero.

Parameters:
- DW, 16, coefficient width (signed).
- NBANK, 2, number of ping-pong banks (fixed at 2; only 2 is supported).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  coefficient write strobe.
- wr_idx  in  6  zigzag scan index of coefficient.
- wr_data  in  DW  signed coefficient value.
- blk_mode  in  1  0 = 4x4, 1 = 8x8; sampled only with blk_done.
- blk_done  in  1  closes the block currently being written.
- wr_ready  out  1  a bank is free for writing.
- idct4  out  2  00 idle, 01 4x4 coefficient valid, 10 8x8 coefficient valid.
- start  out  1  high with the first coefficient of each block.
- coef_out  out  DW  raster-ordered coefficient to idct_top in.

Behaviour:
- Reset (async, rst_n=0):
  - idct4=00, start=0, coef_out=0.
  - Both banks empty, written-bitmaps cleared, write bank pointer = 0, read pointer = 0.
  - wr_ready=1 from the first edge after release.
- Per-bank storage: 64 x DW data plus a 64-bit written bitmap. The read path returns 0 where the bitmap bit is clear, so no memory clear pass is needed.
- Write side:
  - While wr_ready=1 and wr_en=1, wr_idx is mapped through the zigzag LUT to a raster address, data is stored, and the bitmap bit is set.
  - Rewriting the same index overwrites the value (last write wins).
  - Mode 4x4: the 4x4 zigzag table applies (0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15). wr_idx>=16 is ignored.
  - Mode 8x8: the standard 8x8 zigzag table applies.
  - The mode used for mapping is the blk_mode present on each write cycle; upstream holds it constant for the whole block.
  - blk_done at an edge: the same-cycle write (if any) is included, then the bank is marked full with the sampled mode and the write pointer toggles.
  - If no bank is free, wr_ready=0; wr_en and blk_done are ignored (dropped, no error).
- Read FSM, states IDLE / STREAM:
  - IDLE -> STREAM when the bank at the read pointer is full. Load cnt=0 and last = 15 or 63 according to the stored mode.
  - STREAM:
    - Each cycle, register coef_out = bank[rd_ptr][cnt] (0 if not written).
    - Register idct4 = 01 or 10 per mode, and start = (cnt==0).
    - Increment cnt.
  - At cnt==last:
    - Clear the bank's full flag and bitmap.
    - Toggle the read pointer.
    - If the other bank is already full, continue STREAM with cnt=0 and no gap cycle. Otherwise go to IDLE.
  - idct4 returns to 00 the cycle after the last coefficient when going idle.
- Latency: first coefficient on the outputs 2 clocks after the blk_done edge when the reader is idle.
- Throughput: one coefficient per clock. There is no backpressure; idct_top accepts continuously.
- Simultaneous release and refill:
  - The reader releasing bank X and the writer closing bank Y on the same edge are both honoured.
  - The released bank X is writable (wr_ready=1) on the next cycle.
- A write to the bank being streamed is impossible by construction: the write pointer only targets empty banks.
- Reset mid-stream: the stream aborts immediately, outputs go to the reset values, and all buffered data is discarded.

Decomposition:
- Package idct_pkg holds:
  - the idct4 codes (IDCT_IDLE=2'b00, IDCT_4X4=2'b01, IDCT_8X8=2'b10);
  - the block lengths (16, 64);
  - the FSM state encoding.
- Sub-module zigzag_lut: combinational, inputs mode + 6-bit index, outputs 6-bit raster address plus an out-of-range flag.

Test Plan:
- 4x4 single block: write idx0=100, idx1=-5, idx2=7, blk_mode=0, blk_done.
  - -> 16 outputs with idct4=01 and start on the first only.
  - -> raster values 100, -5, 0, 0, 7, 0 ... 0.
  - -> first output 2 clocks after blk_done.
- 8x8 full block: write idx k = k for k=0..63, blk_mode=1.
  - -> 64 outputs in raster order, e.g. raster[1]=1, raster[8]=2, raster[63]=63.
  - -> idct4=10 throughout, then 00.
- Back-to-back: an 8x8 block then a 4x4 block, the second closed during streaming of the first.
  - -> 80 contiguous coefficients with no idle cycle between blocks; start pulses at coefficient 0 and 64.
  - -> idct4 switches 10 -> 01 at the boundary.
- Full buffers: close 2 blocks while the reader is streaming.
  - -> wr_ready=0 while both banks are full.
  - -> a wr_en of value 99 during that time is dropped and never appears.
  - -> wr_ready=1 the cycle after the first block's last coefficient.
- Overwrite and range: in 4x4 mode, write idx3=4 then idx3=9, plus idx20=55.
  - -> raster[8]=9.
  - -> 55 never appears.
- Reset mid-operation: assert rst_n=0 at coefficient 30 of an 8x8 stream.
  - -> idct4=00, start=0, coef_out=0 asynchronously.
  - -> after release, no residual output and wr_ready=1.

Source files
------------

// File: rtl/idct_pkg.sv
// ---------------------------------------------------------------------------
// idct_pkg
// Shared definitions for the IDCT coefficient feeder:
//   - idct4 output codes driven towards idct_top
//   - block lengths and the derived last-coefficient counts
//   - read FSM state encoding
//   - helper mapping a block mode onto its idct4 code
// ---------------------------------------------------------------------------
package idct_pkg;

    // idct4 codes seen by idct_top
    localparam logic [1:0] IDCT_IDLE = 2'b00;
    localparam logic [1:0] IDCT_4X4  = 2'b01;
    localparam logic [1:0] IDCT_8X8  = 2'b10;

    // Coefficients per block
    localparam int BLK_LEN_4X4 = 16;
    localparam int BLK_LEN_8X8 = 64;

    // Index of the final coefficient of a block (stream counter end value)
    localparam logic [5:0] LAST_4X4 = 6'(BLK_LEN_4X4 - 1);
    localparam logic [5:0] LAST_8X8 = 6'(BLK_LEN_8X8 - 1);

    // Read-side FSM
    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Block mode (0 = 4x4, 1 = 8x8) to idct4 "coefficient valid" code
    function automatic logic [1:0] idct_code(input logic mode);
        return mode ? IDCT_8X8 : IDCT_4X4;
    endfunction

    // Block mode to the stream counter end value
    function automatic logic [5:0] last_of(input logic mode);
        return mode ? LAST_8X8 : LAST_4X4;
    endfunction

endpackage

// File: rtl/zigzag_lut.sv
// ---------------------------------------------------------------------------
// zigzag_lut
// Combinational map from a zigzag scan index to a raster address.
// Ports:
//   mode          in  1  0 = 4x4 table, 1 = 8x8 table
//   idx           in  6  zigzag scan index
//   raster        out 6  raster address inside the block
//   out_of_range  out 1  index does not exist in the selected block size
// In 4x4 mode the raster address is row*4+col (0..15).
// ---------------------------------------------------------------------------
module zigzag_lut (
    input  logic       mode,
    input  logic [5:0] idx,
    output logic [5:0] raster,
    output logic       out_of_range
);

    always_comb begin
        raster       = 6'd0;
        out_of_range = 1'b0;
        if (!mode) begin
            // Only indices 0..15 exist in a 4x4 block
            out_of_range = (idx[5:4] != 2'b00);
            case (idx[3:0])
                4'd0:  raster = 6'd0;
                4'd1:  raster = 6'd1;
                4'd2:  raster = 6'd4;
                4'd3:  raster = 6'd8;
                4'd4:  raster = 6'd5;
                4'd5:  raster = 6'd2;
                4'd6:  raster = 6'd3;
                4'd7:  raster = 6'd6;
                4'd8:  raster = 6'd9;
                4'd9:  raster = 6'd12;
                4'd10: raster = 6'd13;
                4'd11: raster = 6'd10;
                4'd12: raster = 6'd7;
                4'd13: raster = 6'd11;
                4'd14: raster = 6'd14;
                4'd15: raster = 6'd15;
            endcase
        end else begin
            case (idx)
                6'd0:  raster = 6'd0;   6'd1:  raster = 6'd1;   6'd2:  raster = 6'd8;   6'd3:  raster = 6'd16;
                6'd4:  raster = 6'd9;   6'd5:  raster = 6'd2;   6'd6:  raster = 6'd3;   6'd7:  raster = 6'd10;
                6'd8:  raster = 6'd17;  6'd9:  raster = 6'd24;  6'd10: raster = 6'd32;  6'd11: raster = 6'd25;
                6'd12: raster = 6'd18;  6'd13: raster = 6'd11;  6'd14: raster = 6'd4;   6'd15: raster = 6'd5;
                6'd16: raster = 6'd12;  6'd17: raster = 6'd19;  6'd18: raster = 6'd26;  6'd19: raster = 6'd33;
                6'd20: raster = 6'd40;  6'd21: raster = 6'd48;  6'd22: raster = 6'd41;  6'd23: raster = 6'd34;
                6'd24: raster = 6'd27;  6'd25: raster = 6'd20;  6'd26: raster = 6'd13;  6'd27: raster = 6'd6;
                6'd28: raster = 6'd7;   6'd29: raster = 6'd14;  6'd30: raster = 6'd21;  6'd31: raster = 6'd28;
                6'd32: raster = 6'd35;  6'd33: raster = 6'd42;  6'd34: raster = 6'd49;  6'd35: raster = 6'd56;
                6'd36: raster = 6'd57;  6'd37: raster = 6'd50;  6'd38: raster = 6'd43;  6'd39: raster = 6'd36;
                6'd40: raster = 6'd29;  6'd41: raster = 6'd22;  6'd42: raster = 6'd15;  6'd43: raster = 6'd23;
                6'd44: raster = 6'd30;  6'd45: raster = 6'd37;  6'd46: raster = 6'd44;  6'd47: raster = 6'd51;
                6'd48: raster = 6'd58;  6'd49: raster = 6'd59;  6'd50: raster = 6'd52;  6'd51: raster = 6'd45;
                6'd52: raster = 6'd38;  6'd53: raster = 6'd31;  6'd54: raster = 6'd39;  6'd55: raster = 6'd46;
                6'd56: raster = 6'd53;  6'd57: raster = 6'd60;  6'd58: raster = 6'd61;  6'd59: raster = 6'd54;
                6'd60: raster = 6'd47;  6'd61: raster = 6'd55;  6'd62: raster = 6'd62;  6'd63: raster = 6'd63;
            endcase
        end
    end

endmodule

// File: rtl/idct_coef_feeder.sv
// ---------------------------------------------------------------------------
// idct_coef_feeder
// Collects sparse zigzag-ordered coefficient writes into a two-bank
// ping-pong buffer and streams each closed block in raster order to
// idct_top, one coefficient per clock with no backpressure.
// Ports:
//   clk       in  1   system clock, rising edge
//   rst_n     in  1   asynchronous active-low reset
//   wr_en     in  1   coefficient write strobe (taken only while wr_ready)
//   wr_idx    in  6   zigzag scan index
//   wr_data   in  DW  signed coefficient
//   blk_mode  in  1   0 = 4x4, 1 = 8x8
//   blk_done  in  1   closes the block being written (taken only while wr_ready)
//   wr_ready  out 1   write bank is empty and accepting data
//   idct4     out 2   00 idle, 01 4x4 coefficient valid, 10 8x8 coefficient valid
//   start     out 1   marks the first coefficient of a block
//   coef_out  out DW  raster-ordered coefficient
// Handshake: the write side is a valid/ready pair where wr_en/blk_done are
// the valids and wr_ready the ready; a beat is taken only on an edge where
// both are high, anything offered while wr_ready is low is dropped. The
// output stream has no ready: idct4 != 00 means coef_out is valid that cycle.
// ---------------------------------------------------------------------------
module idct_coef_feeder
    import idct_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NBANK = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [5:0]    wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic          blk_mode,
    input  logic          blk_done,
    output logic          wr_ready,
    output logic [1:0]    idct4,
    output logic          start,
    output logic [DW-1:0] coef_out
);

    // Zigzag to raster mapping of the incoming write
    logic [5:0] lut_raster;
    logic       lut_oor;

    zigzag_lut u_zigzag_lut (
        .mode         (blk_mode),
        .idx          (wr_idx),
        .raster       (lut_raster),
        .out_of_range (lut_oor)
    );

    // Coefficient storage. It is never cleared: the written bitmap masks
    // stale contents on the read path.
    logic [DW-1:0] coef_mem [NBANK][64];

    logic             wr_ready_q, wr_ready_d;
    logic             wr_ptr_q,   wr_ptr_d;
    logic             rd_ptr_q,   rd_ptr_d;
    logic [NBANK-1:0] full_q,     full_d;
    logic [NBANK-1:0] mode_q,     mode_d;
    logic [63:0]      written_q [NBANK];
    logic [63:0]      written_d [NBANK];
    rd_state_e        state_q,    state_d;
    logic [5:0]       cnt_q,      cnt_d;
    logic [5:0]       last_q,     last_d;
    logic [1:0]       idct4_q,    idct4_d;
    logic             start_q,    start_d;
    logic [DW-1:0]    coef_q,     coef_d;

    logic wr_fire;
    logic close_fire;

    assign wr_fire    = wr_ready_q & wr_en & ~lut_oor;
    assign close_fire = wr_ready_q & blk_done;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        full_d    = full_q;
        mode_d    = mode_q;
        written_d = written_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        idct4_d   = IDCT_IDLE;
        start_d   = 1'b0;
        coef_d    = '0;

        // ---- write side: only ever touches the empty bank at wr_ptr ----
        if (wr_fire) begin
            written_d[wr_ptr_q][lut_raster] = 1'b1;
        end
        if (close_fire) begin
            full_d[wr_ptr_q] = 1'b1;
            mode_d[wr_ptr_q] = blk_mode;
            wr_ptr_d         = ~wr_ptr_q;
        end

        // ---- read side: only ever touches the full bank at rd_ptr ----
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_ptr_q]) begin
                    state_d = RD_STREAM;
                    cnt_d   = 6'd0;
                    last_d  = last_of(mode_q[rd_ptr_q]);
                end
            end
            RD_STREAM: begin
                coef_d  = written_q[rd_ptr_q][cnt_q] ? coef_mem[rd_ptr_q][cnt_q] : '0;
                idct4_d = idct_code(mode_q[rd_ptr_q]);
                start_d = (cnt_q == 6'd0);
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == last_q) begin
                    // Release the bank; the writer may refill it next cycle
                    full_d[rd_ptr_q]    = 1'b0;
                    written_d[rd_ptr_q] = '0;
                    rd_ptr_d            = ~rd_ptr_q;
                    if (full_q[~rd_ptr_q]) begin
                        // Next block already waiting: continue without a gap
                        cnt_d  = 6'd0;
                        last_d = last_of(mode_q[~rd_ptr_q]);
                    end else begin
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        // Ready reflects the bank the writer will target after this edge,
        // so a same-edge release or close is seen one cycle later.
        wr_ready_d = ~full_d[wr_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            coef_mem[wr_ptr_q][lut_raster] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            full_q     <= '0;
            mode_q     <= '0;
            for (int b = 0; b < NBANK; b++) begin
                written_q[b] <= '0;
            end
            state_q    <= RD_IDLE;
            cnt_q      <= 6'd0;
            last_q     <= 6'd0;
            idct4_q    <= IDCT_IDLE;
            start_q    <= 1'b0;
            coef_q     <= '0;
        end else begin
            wr_ready_q <= wr_ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            mode_q     <= mode_d;
            written_q  <= written_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            idct4_q    <= idct4_d;
            start_q    <= start_d;
            coef_q     <= coef_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign idct4    = idct4_q;
    assign start    = start_q;
    assign coef_out = coef_q;

endmodule

// File: tb/tb_idct_coef_feeder.sv
// ---------------------------------------------------------------------------
// tb_idct_coef_feeder
// Drives zigzag writes and block closes, keeps a raster image model per
// block, pushes the expected {idct4, start, coef} stream into exp_q at
// close time and pops it as the DUT produces coefficients.
// ---------------------------------------------------------------------------
module tb_idct_coef_feeder;
    import idct_pkg::*;

    localparam int DW = 16;
    localparam int EW = DW + 3;

    // ---- clock / reset / DUT ----
    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          wr_en    = 1'b0;
    logic [5:0]    wr_idx   = 6'd0;
    logic [DW-1:0] wr_data  = '0;
    logic          blk_mode = 1'b0;
    logic          blk_done = 1'b0;
    logic          wr_ready;
    logic [1:0]    idct4;
    logic          start;
    logic [DW-1:0] coef_out;

    always #5 clk = ~clk;

    idct_coef_feeder #(.DW(DW), .NBANK(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .blk_mode (blk_mode),
        .blk_done (blk_done),
        .wr_ready (wr_ready),
        .idct4    (idct4),
        .start    (start),
        .coef_out (coef_out)
    );

    // ---- bookkeeping ----
    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_item;
    bit  mon_en    = 1'b0;
    bit  in_stream = 1'b0;
    int  gap_cnt   = 0;
    int  out_cnt   = 0;

    // ---- reference model ----
    int zz4[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    int zz8[64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    logic [DW-1:0] img[64];

    initial foreach (img[i]) img[i] = '0;

    // ---- scoreboard monitor: samples on the falling edge ----
    always @(negedge clk) begin
        if (mon_en) begin
            if (idct4 !== IDCT_IDLE) begin
                in_stream = 1'b1;
                out_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: idct4=%b start=%b coef=%0d, required no output",
                             idct4, start, $signed(coef_out));
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({idct4, start, coef_out} !== exp_item) begin
                        errors++;
                        $display("FAIL stream_coef: got idct4=%b start=%b coef=%0d, required idct4=%b start=%b coef=%0d",
                                 idct4, start, $signed(coef_out), exp_item[EW-1 -: 2],
                                 exp_item[DW], $signed(exp_item[DW-1:0]));
                    end
                end
            end else begin
                if (in_stream && exp_q.size() != 0) gap_cnt++;
                if (exp_q.size() == 0) in_stream = 1'b0;
            end
        end
    end

    // ---- driver tasks ----
    task automatic write_coef(input int idx, input int data, input logic mode);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_idx   = idx[5:0];
        wr_data  = data[DW-1:0];
        blk_mode = mode;
        blk_done = 1'b0;
        if (mode) img[zz8[idx]] = data[DW-1:0];
        else if (idx < 16) img[zz4[idx]] = data[DW-1:0];
    endtask

    // Returns on the falling edge right after the closing clock edge
    task automatic close_block(input logic mode);
        int n;
        @(negedge clk);
        wr_en    = 1'b0;
        blk_done = 1'b1;
        blk_mode = mode;
        n = mode ? 64 : 16;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(mode ? IDCT_8X8 : IDCT_4X4), ((i == 0) ? 1'b1 : 1'b0), img[i]});
        end
        foreach (img[i]) img[i] = '0;
        @(negedge clk);
        blk_done = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        #1;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d coefficients still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk); #1;
        checks++;
        if (idct4 !== IDCT_IDLE) begin
            errors++;
            $display("FAIL idle_after_block: idct4=%b, required %b", idct4, IDCT_IDLE);
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({idct4, start, coef_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: idct4=%b start=%b coef=%0d, required 00/0/0", idct4, start, coef_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_wr_ready: wr_ready=%b, required 1", wr_ready);
        end
        checks++;
        if (idct4 !== IDCT_IDLE || start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: idct4=%b start=%b, required 00/0", idct4, start);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_4x4_single();
        write_coef(0, 100, 1'b0);
        write_coef(1, -5, 1'b0);
        write_coef(2, 7, 1'b0);
        close_block(1'b0);
        // one clock after the close edge: nothing yet
        checks++;
        if (idct4 !== IDCT_IDLE) begin
            errors++;
            $display("FAIL latency_1clk: idct4=%b, required %b", idct4, IDCT_IDLE);
        end
        @(negedge clk);
        checks++;
        if (idct4 !== IDCT_IDLE) begin
            errors++;
            $display("FAIL latency_2clk: idct4=%b, required %b", idct4, IDCT_IDLE);
        end
        @(negedge clk);
        checks++;
        if (idct4 !== IDCT_4X4 || start !== 1'b1) begin
            errors++;
            $display("FAIL latency_first: idct4=%b start=%b, required %b/1", idct4, start, IDCT_4X4);
        end
        drain(100);
    endtask

    task automatic test_8x8_full();
        for (int k = 0; k < 64; k++) write_coef(k, k, 1'b1);
        close_block(1'b1);
        drain(200);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 64; k++) write_coef(k, int'($urandom_range(0, 4000)) - 2000, 1'b1);
        close_block(1'b1);
        gap_cnt   = 0;
        in_stream = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 4000)) - 2000, 1'b0);
        end
        close_block(1'b0);
        drain(300);
        checks++;
        if (gap_cnt !== 0) begin
            errors++;
            $display("FAIL back_to_back_gap: %0d idle cycles inside stream, required 0", gap_cnt);
        end
    endtask

    task automatic test_full_buffers();
        int base;
        int n;
        bit ready_seen;
        // Block A: 8x8 with zigzag 63 left unwritten (expected 0)
        for (int k = 0; k < 63; k++) write_coef(k, int'($urandom_range(1, 3000)), 1'b1);
        base = out_cnt;
        close_block(1'b1);
        // Block B: 4x4 closed while A streams
        write_coef(0, 11, 1'b0);
        write_coef(5, -22, 1'b0);
        write_coef(15, 33, 1'b0);
        close_block(1'b0);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_wr_ready: wr_ready=%b with both banks full, required 0", wr_ready);
        end
        // Offered while no bank is free: both must be dropped
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 6'd63; wr_data = 16'd99; blk_mode = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        // wr_ready stays low until A's last coefficient is on the outputs
        ready_seen = 1'b0;
        n = 0;
        #1;
        while (out_cnt - base < 64 && n < 200) begin
            if (wr_ready !== 1'b0) ready_seen = 1'b1;
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (ready_seen || out_cnt - base < 64) begin
            errors++;
            $display("FAIL full_hold: early_ready=%b coefs_seen=%0d, required 0 and 64", ready_seen, out_cnt - base);
        end
        @(negedge clk); #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_wr_ready: wr_ready=%b after bank release, required 1", wr_ready);
        end
        // Block C into the released bank
        write_coef(0, -1, 1'b0);
        write_coef(4, 321, 1'b0);
        close_block(1'b0);
        drain(300);
    endtask

    task automatic test_overwrite_range();
        write_coef(3, 4, 1'b0);
        write_coef(3, 9, 1'b0);
        write_coef(20, 55, 1'b0);
        close_block(1'b0);
        drain(100);
    endtask

    task automatic test_reset_mid();
        int base;
        int n;
        int stray;
        for (int k = 0; k < 64; k++) write_coef(k, int'($urandom_range(1, 30000)), 1'b1);
        base = out_cnt;
        close_block(1'b1);
        n = 0;
        #1;
        while (out_cnt - base < 31 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (out_cnt - base != 31 || idct4 !== IDCT_8X8) begin
            errors++;
            $display("FAIL reset_mid_reach: coefs_seen=%0d idct4=%b, required 31/%b", out_cnt - base, idct4, IDCT_8X8);
        end
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checks++;
        if ({idct4, start, coef_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: idct4=%b start=%b coef=%0d, required 00/0/0", idct4, start, coef_out);
        end
        exp_q.delete();
        in_stream = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wr_ready: wr_ready=%b, required 1", wr_ready);
        end
        stray = 0;
        repeat (80) begin
            @(negedge clk);
            if (idct4 !== IDCT_IDLE || start !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_mid_residual: %0d output cycles after reset, required 0", stray);
        end
        mon_en = 1'b1;
    endtask

    // ---- watchdog ----
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---- sequence ----
    initial begin
        test_reset();
        test_4x4_single();
        test_8x8_full();
        test_back_to_back();
        test_full_buffers();
        test_overwrite_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
